reaction_timer_multi: RTL

- Parametrised, multi-round reaction timer. After each start the block waits a pseudo-random delay, lights the LED, and measures the time to stop in ms as a 4-digit packed BCD value.
- A session runs NUM_ROUNDS rounds and then shows the best (lowest) time.
- Drives a 4-digit active-low seven-segment display directly and also exposes results on a status interface for logging.

---
 rtl/reaction_timer_multi.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer: random delay, LED stimulus, BCD ms measurement,
// best-of-session tracking and a multiplexed active-low 4-digit display.
module reaction_timer_multi #(
  parameter int unsigned CLK_PER_MS       = 100000,
  parameter int unsigned MIN_DELAY_MS     = 2000,
  parameter int unsigned DELAY_RANGE_BITS = 13,
  parameter int unsigned TIMEOUT_MS       = 1000,
  parameter int unsigned NUM_ROUNDS       = 3,
  parameter int unsigned SCAN_DIV         = 62500,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              start,
  input  logic                              stop,
  output logic                              led,
  output logic [3:0]                        an,
  output logic [7:0]                        seg,
  output logic [15:0]                       result_bcd,
  output logic                              result_valid,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]   rounds_done
);
  localparam int unsigned RW = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned PW = $clog2(CLK_PER_MS);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(MIN_DELAY_MS + (32'd1 << DELAY_RANGE_BITS));
  localparam logic [DW-1:0] RANGE_MASK = DW'((32'd1 << DELAY_RANGE_BITS) - 32'd1);
  localparam logic [15:0] TIMEOUT_BCD = {4'((TIMEOUT_MS / 1000) % 10), 4'((TIMEOUT_MS / 100) % 10),
                                         4'((TIMEOUT_MS / 10) % 10), 4'(TIMEOUT_MS % 10)};
  localparam logic [15:0] BEST_INIT = 16'h9999;
  localparam logic [7:0]  SEG_H     = 8'b10001001;
  localparam logic [7:0]  SEG_I     = 8'b11111001;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TIMING, S_RESULT, S_FINAL} state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [DW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [15:0]     result_q, result_d;
  logic            valid_q, valid_d;
  logic [RW-1:0]   rounds_q, rounds_d;
  logic [15:0]     best_q, best_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic            tick, enter_wait, enter_result;
  logic [15:0]     res;
  logic [3:0]      an_act;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    result_d     = result_q;
    valid_d      = 1'b0;
    rounds_d     = rounds_q;
    best_d       = best_q;
    enter_wait   = 1'b0;
    enter_result = 1'b0;
    res          = '0;
    tick         = (presc_q == PW'(CLK_PER_MS - 1));
    presc_d      = tick ? '0 : presc_q + PW'(1);
    wcnt_d       = tick ? wcnt_q + DW'(1) : wcnt_q;
    bcd_d        = tick ? bcd_inc(bcd_q) : bcd_q;
    lfsr_d       = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
    scan_d       = (scan_q == SW'(SCAN_DIV - 1)) ? '0 : scan_q + SW'(1);
    idx_d        = (scan_q == SW'(SCAN_DIV - 1)) ? idx_q + 2'd1 : idx_q;

    if (clear) begin
      state_d  = S_IDLE;
      rounds_d = '0;
      best_d   = BEST_INIT;
    end else begin
      case (state_q)
        S_IDLE, S_FINAL: if (start) begin
          enter_wait = 1'b1;
          rounds_d   = '0;
          best_d     = BEST_INIT;
        end
        S_WAIT: begin
          if (stop) begin
            enter_result = 1'b1;
            res          = BEST_INIT;
          end else if (wcnt_q == delay_q) begin
            state_d = S_TIMING;
            presc_d = '0;
            wcnt_d  = '0;
            bcd_d   = '0;
          end
        end
        // Timeout wins over a coincident stop.
        S_TIMING: begin
          if (bcd_q == TIMEOUT_BCD) begin
            enter_result = 1'b1;
            res          = TIMEOUT_BCD;
          end else if (stop) begin
            enter_result = 1'b1;
            res          = bcd_q;
          end
        end
        S_RESULT: if (start) begin
          if (rounds_q < RW'(NUM_ROUNDS)) enter_wait = 1'b1;
          else                            state_d    = S_FINAL;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (enter_wait) begin
      state_d = S_WAIT;
      delay_d = DW'(MIN_DELAY_MS) + (DW'(lfsr_q) & RANGE_MASK);
      presc_d = '0;
      wcnt_d  = '0;
      bcd_d   = '0;
    end
    if (enter_result) begin
      state_d  = S_RESULT;
      result_d = res;
      valid_d  = 1'b1;
      rounds_d = rounds_q + RW'(1);
      if (res < best_q) best_d = res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      delay_q  <= '0;
      wcnt_q   <= '0;
      presc_q  <= '0;
      bcd_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      rounds_q <= '0;
      best_q   <= BEST_INIT;
      scan_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      delay_q  <= delay_d;
      wcnt_q   <= wcnt_d;
      presc_q  <= presc_d;
      bcd_q    <= bcd_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      rounds_q <= rounds_d;
      best_q   <= best_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    an     = 4'b1111;
    seg    = 8'hFF;
    an_act = ~(4'b0001 << idx_q);
    case (state_q)
      S_IDLE: begin
        if (idx_q == 2'd0) begin
          an  = an_act;
          seg = SEG_I;
        end else if (idx_q == 2'd1) begin
          an  = an_act;
          seg = SEG_H;
        end
      end
      S_TIMING: begin
        an  = an_act;
        seg = seg_code(bcd_q[{idx_q, 2'b00} +: 4]);
      end
      S_RESULT: begin
        an  = an_act;
        seg = seg_code(result_q[{idx_q, 2'b00} +: 4]);
      end
      S_FINAL: begin
        an  = an_act;
        seg = seg_code(best_q[{idx_q, 2'b00} +: 4]);
        if (idx_q == 2'd3) seg[7] = 1'b0;
      end
      default: ;
    endcase
  end

  assign led          = (state_q == S_TIMING);
  assign result_bcd   = result_q;
  assign result_valid = valid_q;
  assign rounds_done  = rounds_q;

endmodule
